pio_edge_avalon: RTL

//  Parametrised Avalon-MM parallel I/O slave for the Computer_System control path.
//  - Drives WIDTH output bits with atomic set/clear access.
//  - Synchronises WIDTH input bits and captures edges on them.
//  - Raises a level interrupt from the masked edge-capture bits.
//  - Replaces fixed-width write-only PIO ports; one instance serves HPS control/status of the L-system/VGA engine.

---
 rtl/pio_edge_avalon_pkg.sv | 20 ++
 rtl/pio_edge_avalon_sync.sv | 27 ++
 rtl/pio_edge_avalon.sv | 105 ++++++++++
 3 files changed

// File: rtl/pio_edge_avalon_pkg.sv
// Shared constants for the edge-capturing Avalon-MM parallel I/O slave.
`timescale 1ns/1ps
package pio_edge_avalon_pkg;

  // Word addresses of the register map
  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_IN     = 3'd1,
    ADDR_MASK   = 3'd2,
    ADDR_EDGE   = 3'd3,
    ADDR_OUTSET = 3'd4,
    ADDR_OUTCLR = 3'd5
  } pio_addr_e;

  // Edge selection encodings for the EDGE_TYPE parameter
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_edge_avalon_sync.sv
// WIDTH-wide multi-stage synchroniser for asynchronous inputs.
`timescale 1ns/1ps
module pio_sync_bus #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the inputs through the flop chain; reset clears every stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pio_edge_avalon.sv
// Avalon-MM parallel I/O slave: set/clear outputs, synchronised inputs,
// edge capture with write-1-to-clear and a masked level interrupt.
`timescale 1ns/1ps
module pio_edge_avalon
  import pio_edge_avalon_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  pio_sync_bus #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync)
  );

  // Output register with plain, set and clear write ports
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg <= RESET_OUT;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   out_reg <= wd;
        ADDR_OUTSET: out_reg <= out_reg | wd;
        ADDR_OUTCLR: out_reg <= out_reg & ~wd;
        default:     ;
      endcase
    end
  end

  // Interrupt mask register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask_reg <= '0;
    else if (wr && address == ADDR_MASK) mask_reg <= wd;
  end

  // Edge detector and write-1-to-clear selection
  always_comb begin
    det = '0;
    clr = '0;
    if (EDGE_TYPE == EDGE_FALL)     det = ~sync & prev;
    else if (EDGE_TYPE == EDGE_ANY) det = (sync & ~prev) | (~sync & prev);
    else                            det = sync & ~prev;
    if (wr && address == ADDR_EDGE) clr = wd;
  end

  // Previous synchronised sample and sticky edge capture; a new detect beats a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev     <= '0;
      edge_cap <= '0;
    end else begin
      prev     <= sync;
      edge_cap <= det | (edge_cap & ~clr);
    end
  end

  // Zero-latency read mux, zero-extended to the bus width
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = out_reg;
      ADDR_IN:   readdata[WIDTH-1:0] = sync;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_reg;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_cap;
      default:   readdata = '0;
    endcase
  end

  assign out_port = out_reg;
  assign irq      = |(edge_cap & mask_reg);

endmodule
